// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the physical memory bus initiator.
// Holds the transfer state enum, the word size and the default line and
// watchdog parameters used by mem_line_master and mem_xfer_watchdog.
package mem_bus_pkg;

    // Bytes per bus word; the low address bits below a word are always zero.
    localparam int WORD_BYTES = 4;

    // Default line geometry and watchdog limit.
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_TIMEOUT        = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } xfer_state_e;

    // Number of address bits that select a byte inside one word.
    function automatic int byte_bits();
        return $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/mem_xfer_watchdog.sv
// Access watchdog: counts cycles spent waiting for the memory acknowledge.
// Ports: clk, clrn (async active-low reset), clr (zero the count),
//        en (count this cycle), expired (en and TIMEOUT cycles reached).
module mem_xfer_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic clrn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // expired fires during the TIMEOUT-th enabled cycle, so the owner can
    // leave on that same clock edge.
    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_line_master.sv
// Cache-line transfer initiator for the physical memory bus. Moves one line
// as single-word strobe/rw/ready transactions, critical word first with wrap.
// Ports: req_* (line request from cache, req_ready high only when idle),
//        wb_idx/wb_data (writeback word select and data from cache array),
//        fill_valid/fill_idx/fill_data (registered fill word pulse),
//        done/err (end-of-transfer pulse, err on watchdog abort),
//        mem_* (physical memory bus, mem_dout valid only with mem_ready).
// Build option: define MEM_TIMEOUT_EN to enable the access watchdog, which
// aborts the remaining line after TIMEOUT unacknowledged ACCESS cycles.
module mem_line_master
    import mem_bus_pkg::*;
#(
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int TIMEOUT        = DEF_TIMEOUT,
    localparam int IW = $clog2(WORDS_PER_LINE),
    localparam int BW = $clog2(WORD_BYTES)
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [31:0]   req_addr,
    output logic [IW-1:0] wb_idx,
    input  logic [31:0]   wb_data,
    output logic          fill_valid,
    output logic [IW-1:0] fill_idx,
    output logic [31:0]   fill_data,
    output logic          done,
    output logic          err,
    output logic [31:0]   mem_a,
    output logic [31:0]   mem_din,
    output logic          mem_strobe,
    output logic          mem_rw,
    input  logic [31:0]   mem_dout,
    input  logic          mem_ready
);

    localparam int LB = IW + BW;

    if (WORDS_PER_LINE < 2 || WORDS_PER_LINE > 16 ||
        (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0 ||
        TIMEOUT < 1 || BW != byte_bits()) begin : g_bad_cfg
        $error("mem_line_master: illegal parameter values");
    end

    xfer_state_e   state_q, state_d;
    logic [31:LB]  base_q, base_d;
    logic          write_q, write_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          strobe_q, strobe_d;
    logic          fill_valid_q, fill_valid_d;
    logic [IW-1:0] fill_idx_q, fill_idx_d;
    logic [31:0]   fill_data_q, fill_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          wd_expired;
    logic          last_word;

`ifdef MEM_TIMEOUT_EN
    // Held clear outside ACCESS so every word starts a fresh count.
    mem_xfer_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .clrn   (clrn),
        .clr    (state_q != ST_ACCESS),
        .en     (state_q == ST_ACCESS),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // idx wraps naturally at IW bits; cnt tracks words already moved.
    assign last_word = (cnt_q == IW'(WORDS_PER_LINE - 1));

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        write_d      = write_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        strobe_d     = strobe_q;
        fill_valid_d = 1'b0;
        fill_idx_d   = fill_idx_q;
        fill_data_d  = fill_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    base_d      = req_addr[31:LB];
                    write_d     = req_write;
                    idx_d       = req_addr[LB-1:BW];
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    strobe_d    = 1'b1;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An acknowledge in the expiry cycle still completes the word.
                if (mem_ready) begin
                    if (!write_q) begin
                        fill_valid_d = 1'b1;
                        fill_idx_d   = idx_q;
                        fill_data_d  = mem_dout;
                    end
                    strobe_d = 1'b0;
                    state_d  = ST_GAP;
                end else if (wd_expired) begin
                    strobe_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_GAP: begin
                idx_d = idx_q + 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (last_word) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    strobe_d = 1'b1;
                    state_d  = ST_ACCESS;
                end
            end
            ST_DONE: begin
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                strobe_d    = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            strobe_q     <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_idx_q   <= '0;
            fill_data_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            strobe_q     <= strobe_d;
            fill_valid_q <= fill_valid_d;
            fill_idx_q   <= fill_idx_d;
            fill_data_q  <= fill_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Address, direction and data only move at state changes, so they hold
    // steady for the whole ACCESS phase.
    assign mem_a      = {base_q, idx_q, {BW{1'b0}}};
    assign mem_rw     = write_q & strobe_q;
    assign mem_din    = wb_data;
    assign mem_strobe = strobe_q;
    assign wb_idx     = idx_q;
    assign req_ready  = req_ready_q;
    assign fill_valid = fill_valid_q;
    assign fill_idx   = fill_idx_q;
    assign fill_data  = fill_data_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_line_master.sv
// Self-checking bench for mem_line_master with a behavioural memory model.
// Expected word order, data and timing are derived from the line rules.
module tb_mem_line_master;

    localparam int W  = 4;
    localparam int TO = 64;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [IW-1:0] wb_idx;
    logic [31:0]   wb_data;
    logic          fill_valid;
    logic [IW-1:0] fill_idx;
    logic [31:0]   fill_data;
    logic          done;
    logic          err;
    logic [31:0]   mem_a;
    logic [31:0]   mem_din;
    logic          mem_strobe;
    logic          mem_rw;
    logic [31:0]   mem_dout = '0;
    logic          mem_ready = 1'b0;

    logic [31:0]   wb_seed = '0;
    logic [31:0]   mem_seed = '0;

    always #5 clk = ~clk;

    assign wb_data = wb_seed | {{(32-IW){1'b0}}, wb_idx};

    mem_line_master #(
        .WORDS_PER_LINE(W),
        .TIMEOUT       (TO)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .wb_idx    (wb_idx),
        .wb_data   (wb_data),
        .fill_valid(fill_valid),
        .fill_idx  (fill_idx),
        .fill_data (fill_data),
        .done      (done),
        .err       (err),
        .mem_a     (mem_a),
        .mem_din   (mem_din),
        .mem_strobe(mem_strobe),
        .mem_rw    (mem_rw),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready)
    );

    int total = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    // Memory model: ready in the lat-th strobe cycle, garbage data otherwise.
    int          mode = 0;
    bit          spurious = 1'b0;
    int          wcnt = 0;
    int          lat_cur = 0;
    int          stab_bad = 0;
    logic [31:0] a0, d0;
    logic        rw0;
    logic [31:0] txa_q[$];
    logic        txrw_q[$];
    logic [31:0] txd_q[$];
    int          lat_q[$];
    int          fidx_q[$];
    logic [31:0] fdat_q[$];

    always @(negedge clk) begin
        if (mem_strobe) begin
            if (wcnt == 0) begin
                case (mode)
                    0: lat_cur = 7;
                    1: lat_cur = (lat_q.size() % 2 == 0) ? 1 : 12;
                    2: lat_cur = $urandom_range(1, 10);
                    default: lat_cur = 0;
                endcase
                lat_q.push_back(lat_cur);
                a0 = mem_a;
                rw0 = mem_rw;
                d0 = mem_din;
            end else if (mem_a !== a0 || mem_rw !== rw0 || mem_din !== d0) begin
                stab_bad++;
            end
            wcnt++;
            if (lat_cur != 0 && wcnt == lat_cur) begin
                mem_ready = 1'b1;
                mem_dout = mval(mem_a);
                txa_q.push_back(mem_a);
                txrw_q.push_back(mem_rw);
                txd_q.push_back(mem_din);
            end else begin
                mem_ready = 1'b0;
                mem_dout = $urandom;
            end
        end else begin
            wcnt = 0;
            mem_ready = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_dout = $urandom;
        end
        if (fill_valid) begin
            fidx_q.push_back(int'(fill_idx));
            fdat_q.push_back(fill_data);
        end
    end

    task automatic do_xfer(input bit wr, input logic [31:0] addr,
                           input int md, input logic [31:0] wbs,
                           input bit chain);
        int s;
        int cyc;
        int exp_cyc;
        int ready_hi;
        int strobe_n;
        int n;
        int wi;
        bit got_done;
        bit got_err;
        bit first;
        logic [31:0] base;
        logic [31:0] ea;
        s = int'((addr >> 2) % W);
        base = addr & ~32'(W * 4 - 1);
        mode = md;
        wb_seed = wbs;
        mem_seed = $urandom;
        txa_q.delete();
        txrw_q.delete();
        txd_q.delete();
        lat_q.delete();
        fidx_q.delete();
        fdat_q.delete();
        stab_bad = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr = addr;
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("accept_wait", 32'(cyc < 100), 32'd1);
        if (cyc >= 100) return;
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; the transfer must ignore it.
        req_addr = $urandom;
        req_write = ~wr;
        cyc = 0;
        got_done = 0;
        got_err = 0;
        first = 0;
        ready_hi = 0;
        strobe_n = 0;
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) first = mem_strobe;
            if (req_ready) ready_hi++;
            if (mem_strobe) strobe_n++;
            if (done) begin
                got_done = 1;
                got_err = err;
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        check("strobe_after_accept", 32'(first), 32'd1);
        check("no_ready_busy", 32'(ready_hi), 32'd0);
        check("mem_stable", 32'(stab_bad), 32'd0);
        if (md == 3) begin
            check("to_done_cycle", 32'(cyc), 32'(TO + 1));
            check("to_strobe_cycles", 32'(strobe_n), 32'(TO));
            check("to_err", 32'(got_err), 32'd1);
            check("to_no_txn", 32'(txa_q.size()), 32'd0);
            check("to_no_fill", 32'(fidx_q.size()), 32'd0);
        end else begin
            exp_cyc = 1;
            foreach (lat_q[k]) exp_cyc += lat_q[k] + 1;
            check("done_cycle", 32'(cyc), 32'(exp_cyc));
            check("err_low", 32'(got_err), 32'd0);
            check("txn_count", 32'(txa_q.size()), 32'(W));
            n = (txa_q.size() < W) ? txa_q.size() : W;
            for (int k = 0; k < n; k++) begin
                wi = (s + k) % W;
                ea = base + 32'(wi * 4);
                check($sformatf("addr_w%0d", k), txa_q[k], ea);
                check($sformatf("rw_w%0d", k), 32'(txrw_q[k]), 32'(wr));
                if (wr) check($sformatf("din_w%0d", k), txd_q[k],
                              wbs | 32'(wi));
            end
            check("fill_count", 32'(fidx_q.size()), wr ? 32'd0 : 32'(W));
            n = (fidx_q.size() < W) ? fidx_q.size() : W;
            for (int k = 0; k < n; k++) begin
                wi = (s + k) % W;
                check($sformatf("fill_idx_w%0d", k), 32'(fidx_q[k]), 32'(wi));
                check($sformatf("fill_data_w%0d", k), fdat_q[k],
                      mval(base + 32'(wi * 4)));
            end
        end
        @(negedge clk);
        check("ready_after_done", 32'(req_ready), 32'd1);
        if (!chain) req_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int bad;
        logic [31:0] ra;
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_strobe", 32'(mem_strobe), 32'd0);
        check("rst_rw", 32'(mem_rw), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        check("rst_fill_valid", 32'(fill_valid), 32'd0);
        check("rst_fill_idx", 32'(fill_idx), 32'd0);
        check("rst_fill_data", fill_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wb_idx", 32'(wb_idx), 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        // Critical-word-first fill and a plain writeback, 7-cycle memory.
        do_xfer(1'b0, 32'h1000_0008, 0, 32'h0, 1'b0);
        check("spec_fill_a0", (txa_q.size() > 0) ? txa_q[0] : 32'hX,
              32'h1000_0008);
        do_xfer(1'b1, 32'h2000_2000, 0, 32'hA5A5_0000, 1'b0);

        // Alternating fast/slow acknowledges with stray ready outside ACCESS.
        spurious = 1'b1;
        do_xfer(1'b0, 32'h3000_004C, 1, 32'h0, 1'b0);
        do_xfer(1'b1, 32'h4000_0074, 1, 32'h5A5A_0000, 1'b0);

        // Request held high across the transfer, then back-to-back.
        do_xfer(1'b0, 32'h5000_0104, 0, 32'h0, 1'b1);
        do_xfer(1'b1, 32'h6000_020C, 2, 32'h1234_5670, 1'b0);
        spurious = 1'b0;

        // Reset in the third word's ACCESS phase.
        mode = 0;
        txa_q.delete();
        lat_q.delete();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h7000_0004;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!(txa_q.size() == 2 && mem_strobe && !mem_ready)
                   && cyc < 200);
        check("rst3_reached", 32'(cyc < 200), 32'd1);
        #1;
        clrn = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst3_strobe", 32'(mem_strobe), 32'd0);
        check("rst3_ready", 32'(req_ready), 32'd1);
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (done || fill_valid || mem_strobe) bad++;
        end
        clrn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done || fill_valid || mem_strobe) bad++;
        end
        check("rst3_quiet", 32'(bad), 32'd0);
        do_xfer(1'b0, 32'h7000_0004, 0, 32'h0, 1'b0);

        // Randomised transfers.
        for (int i = 0; i < 8; i++) begin
            spurious = 1'($urandom_range(0, 1));
            ra = $urandom;
            do_xfer(1'($urandom_range(0, 1)), ra, 2,
                    $urandom & 32'hFFFF_FFF0, (i != 7) && ($urandom_range(0, 1) == 1));
        end
        spurious = 1'b0;

`ifdef MEM_TIMEOUT_EN
        do_xfer(1'b0, 32'h8000_0008, 3, 32'h0, 1'b0);
        do_xfer(1'b1, 32'h8000_0010, 0, 32'hC3C3_0000, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
